// File: rtl/fpu_wb_master.sv
// fpu_wb_master: Wishbone initiator that runs one FPU operation per command.
// Writes operands/config, polls status, then reads result and exception flags.
module fpu_wb_master #(
  parameter logic [31:0] ADDR_OPA  = 32'h3000_0000,
  parameter logic [31:0] ADDR_OPB  = 32'h3000_0004,
  parameter logic [31:0] ADDR_OPC  = 32'h3000_0008,
  parameter logic [31:0] ADDR_FRM  = 32'h3000_000C,
  parameter logic [31:0] ADDR_OPV  = 32'h3000_0010,
  parameter logic [31:0] ADDR_STAT = 32'h3000_0014,
  parameter logic [31:0] ADDR_RES  = 32'h3000_0018,
  parameter logic [31:0] ADDR_EXC  = 32'h3000_001C,
  parameter int ACK_TO   = 16,
  parameter int POLL_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [31:0] cmd_c,
  input  logic [2:0]  cmd_frm,
  input  logic [10:0] cmd_sel,
  input  logic [1:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_exc,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  typedef enum logic [2:0] {IDLE, WRITE, GAP, POLL, READ_RES, READ_EXC, RESP} state_t;
  localparam logic [15:0] TO_LAST   = 16'(ACK_TO - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX);
  state_t state, nxt, ack_nxt;
  logic [31:0] a, b, c, wr_adr, wr_dat, acc_adr;
  logic [2:0]  frm;
  logic [10:0] sel;
  logic [1:0]  op;
  logic [2:0]  widx;
  logic [15:0] tcnt, pcnt;
  logic        one_hot;
  assign one_hot = (cmd_sel != 11'd0) && ((cmd_sel & (cmd_sel - 11'd1)) == 11'd0);
  // widx walks A,B,C,FRM,OPV; C is skipped for non-FMA units
  always_comb begin
    wr_adr = widx == 3'd0 ? ADDR_OPA : widx == 3'd1 ? ADDR_OPB : widx == 3'd2 ? ADDR_OPC :
             widx == 3'd3 ? ADDR_FRM : ADDR_OPV;
    wr_dat = widx == 3'd0 ? a : widx == 3'd1 ? b : widx == 3'd2 ? c :
             widx == 3'd3 ? {29'd0, frm} : {19'd0, sel, op};
    acc_adr = state == WRITE ? wr_adr : state == POLL ? ADDR_STAT :
              state == READ_RES ? ADDR_RES : ADDR_EXC;
    ack_nxt = state == WRITE ? (widx == 3'd4 ? POLL : WRITE) :
              state == POLL ? (wbm_dat_i[0] ? READ_RES : pcnt == POLL_LAST ? RESP : POLL) :
              state == READ_RES ? READ_EXC : RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= IDLE;
      nxt <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_result <= '0;
      rsp_exc <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      frm <= '0;
      sel <= '0;
      op <= '0;
      widx <= '0;
      tcnt <= '0;
      pcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            a <= cmd_a;
            b <= cmd_b;
            c <= cmd_c;
            frm <= cmd_frm;
            sel <= cmd_sel;
            op <= cmd_op;
            cmd_ready <= 1'b0;
            rsp_result <= '0;
            rsp_exc <= '0;
            rsp_err <= !one_hot;
            widx <= '0;
            pcnt <= '0;
            state <= one_hot ? WRITE : RESP;
          end
        end
        GAP: state <= nxt;
        RESP: begin
          if (!rsp_valid) rsp_valid <= 1'b1;
          else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o <= state == WRITE;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= acc_adr;
            wbm_dat_o <= state == WRITE ? wr_dat : 32'd0;
            tcnt <= '0;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o <= 1'b0;
            wbm_sel_o <= '0;
            state <= GAP;
            nxt <= ack_nxt;
            if (state == WRITE) widx <= (widx == 3'd1 && !sel[8]) ? 3'd3 : widx + 3'd1;
            if (state == READ_RES) rsp_result <= wbm_dat_i;
            if (state == READ_EXC) rsp_exc <= wbm_dat_i[4:0];
            if (state == POLL && !wbm_dat_i[0]) begin
              pcnt <= pcnt + 16'd1;
              if (pcnt == POLL_LAST) rsp_err <= 1'b1;
            end
          end else if (tcnt == TO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o <= 1'b0;
            wbm_sel_o <= '0;
            rsp_err <= 1'b1;
            state <= RESP;
          end else tcnt <= tcnt + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: doc/fpu_wb_master.md
# fpu_wb_master

Wishbone initiator that drives the FPU register block from a simple command/response port. It accepts one FPU operation (operands, rounding mode, one-hot unit select, op code), performs the register writes, polls for completion and reads back result and exception flags. It sits between a local sequencer (test harness or on-chip controller) and the FPU's Wishbone slave, replacing firmware-driven register pokes.

## Interface
- ADDR_OPA, default 32'h3000_0000, operand A register address
- ADDR_OPB, default 32'h3000_0004, operand B register address
- ADDR_OPC, default 32'h3000_0008, operand C register address
- ADDR_FRM, default 32'h3000_000C, rounding-mode register address
- ADDR_OPV, default 32'h3000_0010, op-valids register address ({valid[10:0], op[1:0]})
- ADDR_STAT, default 32'h3000_0014, status register; bit 0 = result ready
- ADDR_RES, default 32'h3000_0018, result register address
- ADDR_EXC, default 32'h3000_001C, exceptions register address (bits [4:0])
- ACK_TO, default 16, max cycles to wait for wbm_ack_i per access
- POLL_MAX, default 64, max status reads before giving up
- clk  in  1  clock
- rst_l  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
- cmd_a, cmd_b, cmd_c  in  32 each  operands
- cmd_frm  in  3  rounding mode
- cmd_sel  in  11  unit select, must be one-hot (bit 10 sqrt … bit 0 fclass)
- cmd_op  in  2  op code
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_result  out  32  FPU result
- rsp_exc  out  5  exception flags
- rsp_err  out  1  command aborted (bad select, ack timeout, poll timeout)
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control
- wbm_sel_o  out  4  always 4'hF during a cycle, 0 otherwise
- wbm_adr_o, wbm_dat_o  out  32 each  address / write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge

## Operation
- States: IDLE, WRITE, GAP, POLL, READ_RES, READ_EXC, RESP.
- IDLE: cmd_ready=1. On accept, latch all cmd fields. If cmd_sel not one-hot (zero or >1 bit): go to RESP with rsp_err=1, result/exc=0, no bus traffic.
- WRITE sequence: A, B, C (only if cmd_sel[8], FMA), FRM, OPV. OPV data = {19'b0, cmd_sel, cmd_op}. B written for all units (harmless for unary ops).
- POLL: read ADDR_STAT; bit 0 set -> READ_RES, else repeat. Poll count > POLL_MAX -> RESP with rsp_err=1.
- READ_RES latches wbm_dat_i into rsp_result; READ_EXC latches wbm_dat_i[4:0] into rsp_exc.
- RESP: rsp_valid=1, fields stable until rsp_ready; then IDLE.
- Ack timeout: access not acked within ACK_TO cycles of stb rising -> drop cyc/stb, RESP with rsp_err=1, result/exc fields hold what was read so far (0 if not read).
- wbm_dat_i ignored outside read acks; ack when stb low ignored.

## Timing
- Reset (rst_l=0 at clk edge): state IDLE; cmd_ready=1 after reset deasserts (0 during reset); rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o=0; wbm_sel_o=0; wbm_adr_o, wbm_dat_o, rsp_result=0, rsp_exc=0; poll and timeout counters 0. Reset mid-transaction aborts immediately, cyc/stb low next cycle.
- Wishbone classic: cyc/stb/we/adr/dat registered, asserted the cycle after state entry, held until the cycle ack is sampled high; deasserted next cycle.
- Every access followed by exactly one GAP cycle with cyc=stb=0 (slave latch recovery).
- Zero-wait slave (ack in first stb cycle): each access 2 cycles + 1 GAP = 3 cycles.
- Min latency, non-FMA, ready on first poll: 4 writes + 3 reads = 7 accesses = 21 cycles from accept to rsp_valid, plus 1 cycle to register response.
- cmd_ready low from accept cycle+1 until cycle after rsp handshake; back-to-back commands need ≥1 IDLE cycle.
- Timeout counter resets per access; asserting ack on cycle ACK_TO still counts as success.

## Test plan
- Add 1.0+2.0: cmd_a=3F800000, cmd_b=40000000, cmd_sel bit 6, op=0, zero-wait slave returning stat=1, res=40400000, exc=0 -> exact write order A,B,FRM,OPV(=0x0000_0100), rsp_result=40400000, rsp_exc=0, rsp_err=0, rsp_valid at cycle 22.
- FMA: cmd_sel bit 8, cmd_c=3F800000 -> C write present at ADDR_OPC between B and FRM, OPV=0x0000_0400.
- Divide with slow completion: stat=0 for 5 polls then 1, res=3F000000, exc=5'b00001 -> 6 status reads, rsp_result=3F000000, rsp_exc=01.
- Bad select: cmd_sel=11'b000_0110_0000 -> no cyc ever asserted, rsp_valid next cycle with rsp_err=1.
- Ack timeout: slave never acks OPB write -> stb drops after 16 cycles, rsp_err=1; poll timeout: stat stays 0 -> exactly 65 reads then rsp_err=1.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles -> response stable; assert rst_l=0 during POLL -> cyc/stb/rsp_valid 0 next edge, cmd_ready=1 after release.
